dcf77_encoder: RTL and testbench

- Generates a DCF77 time-code pulse stream (seconds marks, 100/200 ms widths, missing second-59 mark) from the date/time held on an `if_date_time` interface.
- Feeds the receiver chain in loopback, so the receiver and display path can be exercised without an antenna.
- Sits beside the clock module and takes the same `bcd_t` digit fields the display decoder consumes.

---
 rtl/dcf77_encoder_pkg.sv | 35 +++
 rtl/if_date_time.sv | 14 +
 rtl/dcf77_frame_builder.sv | 35 +++
 rtl/dcf77_encoder.sv | 127 ++++++++++++
 tb/tb_dcf77_encoder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dcf77_encoder_pkg.sv
// Shared types and constants for the DCF77 time-code encoder.
// Also holds the frame bit positions and the even-parity helper.
package types;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } dcf_state_e;

    localparam int DCF77_FRAME_LEN   = 60;
    localparam int DCF77_MS_ZERO     = 100;
    localparam int DCF77_MS_ONE      = 200;
    localparam int DCF77_MS_PER_SEC  = 1000;

    // Start index of each field inside the 59-bit frame
    localparam int DCF77_BIT_CEST     = 17;
    localparam int DCF77_BIT_CET      = 18;
    localparam int DCF77_BIT_START    = 20;
    localparam int DCF77_BIT_MIN      = 21;
    localparam int DCF77_BIT_MIN_PAR  = 28;
    localparam int DCF77_BIT_HOUR     = 29;
    localparam int DCF77_BIT_HOUR_PAR = 35;
    localparam int DCF77_BIT_DAY      = 36;
    localparam int DCF77_BIT_DOW      = 42;
    localparam int DCF77_BIT_MONTH    = 45;
    localparam int DCF77_BIT_YEAR     = 50;
    localparam int DCF77_BIT_DATE_PAR = 58;

    function automatic logic even_parity(input logic [21:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/if_date_time.sv
// Date/time bundle shared by the clock, the display decoder and the DCF77 encoder.
// Each field is two BCD digits: index 1 = tens, index 0 = units.
interface if_date_time;
    types::bcd_t [1:0] second;
    types::bcd_t [1:0] minute;
    types::bcd_t [1:0] hour;
    types::bcd_t [1:0] day;
    types::bcd_t [1:0] month;
    types::bcd_t [1:0] year;
    logic [2:0]        day_of_week;

    modport rd (input minute, hour, day, month, year, day_of_week);
    modport wr (output second, minute, hour, day, month, year, day_of_week);
endinterface

// File: rtl/dcf77_frame_builder.sv
// Combinational mapping of the date/time fields and the CEST flag to the 59 DCF77 data bits.
// Tens digits are cut to their field width; parity covers exactly the bits that are sent.
module dcf77_frame_builder
    import types::*;
(
    if_date_time.rd                    clock,
    input  logic                       cest_i,
    output logic [DCF77_FRAME_LEN-2:0] frame_o
);

    logic [6:0]  min_bits;
    logic [5:0]  hour_bits;
    logic [21:0] date_bits;

    always_comb begin
        min_bits  = {clock.minute[1][2:0], clock.minute[0]};
        hour_bits = {clock.hour[1][1:0], clock.hour[0]};
        date_bits = {clock.year[1], clock.year[0],
                     clock.month[1][0], clock.month[0],
                     clock.day_of_week,
                     clock.day[1][1:0], clock.day[0]};

        frame_o                        = '0;
        frame_o[DCF77_BIT_CEST]        = cest_i;
        frame_o[DCF77_BIT_CET]         = ~cest_i;
        frame_o[DCF77_BIT_START]       = 1'b1;
        frame_o[DCF77_BIT_MIN +: 7]    = min_bits;
        frame_o[DCF77_BIT_MIN_PAR]     = even_parity({15'd0, min_bits});
        frame_o[DCF77_BIT_HOUR +: 6]   = hour_bits;
        frame_o[DCF77_BIT_HOUR_PAR]    = even_parity({16'd0, hour_bits});
        frame_o[DCF77_BIT_DAY +: 22]   = date_bits;
        frame_o[DCF77_BIT_DATE_PAR]    = even_parity(date_bits);
    end

endmodule

// File: rtl/dcf77_encoder.sv
// DCF77 pulse-stream generator: 1 ms prescaler, ms/second counters and a latched 59-bit frame.
// Optional macro DCF77_ENC_ERR_INJECT_EN adds inject_err, which flips the date parity of the latched frame.
module dcf77_encoder
    import types::*;
#(
    parameter int CLK_FREQ = 50_000_000
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    if_date_time.rd    clock,
    input  logic       cest,
`ifdef DCF77_ENC_ERR_INJECT_EN
    input  logic       inject_err,
`endif
    output logic       dcf_out,
    output logic [5:0] second,
    output logic       minute_strobe
);

    localparam int             DIV       = CLK_FREQ / 1000;
    localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_TOP = PW'(DIV - 1);
    localparam logic [9:0]     MS_LAST   = 10'(DCF77_MS_PER_SEC - 1);
    localparam logic [9:0]     MS_ZERO   = 10'(DCF77_MS_ZERO);
    localparam logic [9:0]     MS_ONE    = 10'(DCF77_MS_ONE);
    localparam logic [5:0]     SEC_LAST  = 6'(DCF77_FRAME_LEN - 1);

    dcf_state_e                 state_q, state_d;
    logic [PW-1:0]              presc_q, presc_d;
    logic [9:0]                 ms_q, ms_d;
    logic [5:0]                 sec_q, sec_d;
    logic [DCF77_FRAME_LEN-2:0] frame_q, frame_d;
    logic                       dcf_q, dcf_d;
    logic                       strobe_q, strobe_d;
    logic [DCF77_FRAME_LEN-2:0] frame_built;
    logic [DCF77_FRAME_LEN-2:0] frame_new;
    logic                       bit_val;

    dcf77_frame_builder u_frame_builder (
        .clock   (clock),
        .cest_i  (cest),
        .frame_o (frame_built)
    );

    always_comb begin
        frame_new = frame_built;
`ifdef DCF77_ENC_ERR_INJECT_EN
        frame_new[DCF77_BIT_DATE_PAR] = frame_built[DCF77_BIT_DATE_PAR] ^ inject_err;
`endif
        state_d  = state_q;
        presc_d  = presc_q;
        ms_d     = ms_q;
        sec_d    = sec_q;
        frame_d  = frame_q;
        strobe_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_RUN;
                    presc_d  = PRESC_TOP;
                    ms_d     = '0;
                    sec_d    = '0;
                    frame_d  = frame_new;
                    strobe_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    ms_d    = '0;
                    sec_d   = '0;
                end else if (presc_q == '0) begin
                    presc_d = PRESC_TOP;
                    if (ms_q == MS_LAST) begin
                        ms_d = '0;
                        if (sec_q == SEC_LAST) begin
                            // Minute wrap: next frame is captured exactly at the marker
                            sec_d    = '0;
                            frame_d  = frame_new;
                            strobe_d = 1'b1;
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end else begin
                        ms_d = ms_q + 10'd1;
                    end
                end else begin
                    presc_d = presc_q - PW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bit_val = (sec_d < SEC_LAST) ? frame_d[sec_d] : 1'b0;
        dcf_d   = (state_d == ST_RUN) && (sec_d < SEC_LAST) &&
                  (ms_d < (bit_val ? MS_ONE : MS_ZERO));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            ms_q     <= '0;
            sec_q    <= '0;
            frame_q  <= '0;
            dcf_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            sec_q    <= sec_d;
            frame_q  <= frame_d;
            dcf_q    <= dcf_d;
            strobe_q <= strobe_d;
        end
    end

    assign dcf_out       = dcf_q;
    assign second        = sec_q;
    assign minute_strobe = strobe_q;

endmodule

// File: tb/tb_dcf77_encoder.sv
// Directed bench for dcf77_encoder at CLK_FREQ=1000 (one ms tick per clock).
module tb_dcf77_encoder;
    import types::*;

    localparam int CLK_FREQ = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cest;
`ifdef DCF77_ENC_ERR_INJECT_EN
    logic       inject_err;
`endif
    logic       dcf_out;
    logic [5:0] second;
    logic       minute_strobe;

    if_date_time dt ();

    int n_checks = 0;
    int n_pass   = 0;
    int width  [60];
    int width2 [60];
    logic [58:0] exp_f1;

    dcf77_encoder #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .clock         (dt),
        .cest          (cest),
`ifdef DCF77_ENC_ERR_INJECT_EN
        .inject_err    (inject_err),
`endif
        .dcf_out       (dcf_out),
        .second        (second),
        .minute_strobe (minute_strobe)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived frame for 14:37, dow 1, 04.03.24, winter time
    task automatic build_expected();
        int ones [16] = '{18, 20, 21, 22, 23, 25, 26, 28, 31, 33, 38, 42, 45, 46, 52, 55};
        exp_f1 = '0;
        foreach (ones[i]) exp_f1[ones[i]] = 1'b1;
`ifdef DCF77_ENC_ERR_INJECT_EN
        exp_f1[58] = 1'b1;
`endif
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        cest   = 1'b0;
`ifdef DCF77_ENC_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        dt.second = 8'h00; dt.minute = 8'h37; dt.hour = 8'h14;
        dt.day = 8'h04; dt.month = 8'h03; dt.year = 8'h24; dt.day_of_week = 3'd1;
        repeat (3) step();
        n_checks++; if (dcf_out !== 1'b0) $display("FAIL reset_dcf_out got %b want 0", dcf_out); else n_pass++;
        n_checks++; if (second !== 6'd0) $display("FAIL reset_second got %0d want 0", second); else n_pass++;
        n_checks++; if (minute_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", minute_strobe); else n_pass++;
        enable = 1'b0;
        step();
        reset = 1'b0;
        repeat (2) step();
        n_checks++; if (dcf_out !== 1'b0) $display("FAIL idle_dcf_out got %b want 0", dcf_out); else n_pass++;
        n_checks++; if (minute_strobe !== 1'b0) $display("FAIL idle_strobe got %b want 0", minute_strobe); else n_pass++;
    endtask

    task automatic test_frame_content();
        int s;
        int ms;
        int strobe_hi;
        strobe_hi = 0;
`ifdef DCF77_ENC_ERR_INJECT_EN
        inject_err = 1'b1;
`endif
        enable = 1'b1;
        step();
`ifdef DCF77_ENC_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        n_checks++; if (dcf_out !== 1'b1) $display("FAIL start_dcf_out got %b want 1", dcf_out); else n_pass++;
        n_checks++; if (minute_strobe !== 1'b1) $display("FAIL start_strobe got %b want 1", minute_strobe); else n_pass++;
        for (int c = 0; c < 60000; c++) begin
            s  = c / 1000;
            ms = c % 1000;
            if (ms == 0) begin
                width[s] = 0;
                n_checks++;
                if (second !== 6'(s)) $display("FAIL frame1_second got %0d want %0d", second, s); else n_pass++;
            end
            if (dcf_out === 1'b1) width[s]++;
            if (minute_strobe === 1'b1) strobe_hi++;
            if (c == 30000) dt.minute = 8'h38;
            step();
        end
        n_checks++; if (strobe_hi !== 1) $display("FAIL frame1_strobe_count got %0d want 1", strobe_hi); else n_pass++;
        for (int i = 0; i < 59; i++) begin
            n_checks++;
            if (width[i] !== (exp_f1[i] ? 200 : 100))
                $display("FAIL frame1_width sec %0d got %0d want %0d", i, width[i], exp_f1[i] ? 200 : 100);
            else n_pass++;
        end
        n_checks++; if (width[59] !== 0) $display("FAIL sec59_no_mark got %0d want 0", width[59]); else n_pass++;
    endtask

`ifdef DCF77_ENC_ERR_INJECT_EN
    task automatic test_error_injection();
        n_checks++; if (width[58] !== 200) $display("FAIL inject_bit58 got %0d want 200", width[58]); else n_pass++;
        n_checks++; if (width[28] !== 200) $display("FAIL inject_bit28 got %0d want 200", width[28]); else n_pass++;
        n_checks++; if (width[35] !== 100) $display("FAIL inject_bit35 got %0d want 100", width[35]); else n_pass++;
    endtask
`endif

    task automatic test_minute_wrap();
        int s;
        n_checks++; if (minute_strobe !== 1'b1) $display("FAIL wrap_strobe got %b want 1", minute_strobe); else n_pass++;
        n_checks++; if (second !== 6'd0) $display("FAIL wrap_second got %0d want 0", second); else n_pass++;
        n_checks++; if (dcf_out !== 1'b1) $display("FAIL wrap_dcf_out got %b want 1", dcf_out); else n_pass++;
        for (int c = 0; c < 24000; c++) begin
            s = c / 1000;
            if (c % 1000 == 0) width2[s] = 0;
            if (dcf_out === 1'b1) width2[s]++;
            if (c == 1) begin
                n_checks++;
                if (minute_strobe !== 1'b0) $display("FAIL wrap_strobe_len got %b want 0", minute_strobe); else n_pass++;
            end
            step();
        end
        n_checks++; if (width2[20] !== 200) $display("FAIL frame2_bit20 got %0d want 200", width2[20]); else n_pass++;
        for (int i = 21; i < 24; i++) begin
            n_checks++;
            if (width2[i] !== 100) $display("FAIL frame2_minute sec %0d got %0d want 100", i, width2[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mark();
        int hi;
        hi = 0;
        for (int c = 0; c < 150; c++) begin
            if (dcf_out === 1'b1) hi++;
            step();
        end
        n_checks++; if (hi !== 150) $display("FAIL frame2_bit24_high got %0d want 150", hi); else n_pass++;
        n_checks++; if (dcf_out !== 1'b1) $display("FAIL mid_mark_dcf_out got %b want 1", dcf_out); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++; if (dcf_out !== 1'b0) $display("FAIL rst_mid_dcf_out got %b want 0", dcf_out); else n_pass++;
        n_checks++; if (second !== 6'd0) $display("FAIL rst_mid_second got %0d want 0", second); else n_pass++;
        n_checks++; if (minute_strobe !== 1'b0) $display("FAIL rst_mid_strobe got %b want 0", minute_strobe); else n_pass++;
        step();
        n_checks++; if (dcf_out !== 1'b0) $display("FAIL rst_hold_dcf_out got %b want 0", dcf_out); else n_pass++;
        reset = 1'b0;
        step();
        n_checks++; if (minute_strobe !== 1'b1) $display("FAIL restart_strobe got %b want 1", minute_strobe); else n_pass++;
        n_checks++; if (dcf_out !== 1'b1) $display("FAIL restart_dcf_out got %b want 1", dcf_out); else n_pass++;
    endtask

    task automatic test_enable_drop();
        repeat (1050) step();
        n_checks++; if (second !== 6'd1) $display("FAIL drop_pre_second got %0d want 1", second); else n_pass++;
        n_checks++; if (dcf_out !== 1'b1) $display("FAIL drop_pre_dcf_out got %b want 1", dcf_out); else n_pass++;
        enable = 1'b0;
        step();
        n_checks++; if (dcf_out !== 1'b0) $display("FAIL drop_dcf_out got %b want 0", dcf_out); else n_pass++;
        n_checks++; if (second !== 6'd0) $display("FAIL drop_second got %0d want 0", second); else n_pass++;
        repeat (3) step();
        n_checks++; if (dcf_out !== 1'b0) $display("FAIL drop_idle_dcf_out got %b want 0", dcf_out); else n_pass++;
        enable = 1'b1;
        step();
        n_checks++; if (minute_strobe !== 1'b1) $display("FAIL reenable_strobe got %b want 1", minute_strobe); else n_pass++;
        n_checks++; if (second !== 6'd0) $display("FAIL reenable_second got %0d want 0", second); else n_pass++;
        n_checks++; if (dcf_out !== 1'b1) $display("FAIL reenable_dcf_out got %b want 1", dcf_out); else n_pass++;
        step();
        n_checks++; if (minute_strobe !== 1'b0) $display("FAIL reenable_strobe_len got %b want 0", minute_strobe); else n_pass++;
    endtask

    initial begin
        build_expected();
        test_reset();
        test_frame_content();
`ifdef DCF77_ENC_ERR_INJECT_EN
        test_error_injection();
`endif
        test_minute_wrap();
        test_reset_mid_mark();
        test_enable_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
